// File: rtl/game_state_ctrl_if.sv
// Game state controller bus: frame/start/collision inputs and the game status outputs.
// The master side (top level or bench) drives the inputs; the controller uses the slave side.
interface game_state_ctrl_if;
  logic        frame_tick;
  logic        start_btn;
  logic        collision;
  logic [1:0]  state;
  logic        game_run;
  logic        hit_flash;
  logic        invuln;
  logic [1:0]  lives;
  logic [13:0] score;
  logic [13:0] hi_score;

  modport master (
    output frame_tick, start_btn, collision,
    input  state, game_run, hit_flash, invuln, lives, score, hi_score
  );

  modport slave (
    input  frame_tick, start_btn, collision,
    output state, game_run, hit_flash, invuln, lives, score, hi_score
  );
endinterface

// File: rtl/game_state_ctrl.sv
// Game state controller: IDLE/RUN/HIT/OVER sequencing, score and hi-score keeping,
// lives, hit flashing and post-hit invulnerability.
// Optional feature macro GAME_MULTI_LIFE_EN: when defined, lives/HIT/invulnerability are
// active; when undefined, any accepted collision ends the game immediately.
module game_state_ctrl #(
  parameter int unsigned LIVES_INIT    = 3,
  parameter int unsigned FLASH_FRAMES  = 60,
  parameter int unsigned INVULN_FRAMES = 90,
  parameter int unsigned SCORE_DIV     = 6
) (
  input logic              clk,
  input logic              rst_n,
  game_state_ctrl_if.slave gs
);

  localparam int unsigned DivW   = ($clog2(SCORE_DIV + 1) > 1) ? $clog2(SCORE_DIV + 1) : 1;
  localparam int unsigned FlashW = ($clog2(FLASH_FRAMES + 1) > 3) ? $clog2(FLASH_FRAMES + 1) : 3;
  // At least 4 bits so bit 3 always exists for the blink pattern
  localparam int unsigned InvW   = ($clog2(INVULN_FRAMES + 1) > 4) ? $clog2(INVULN_FRAMES + 1) : 4;
  localparam logic [13:0] ScoreMax = 14'd9999;

`ifdef GAME_MULTI_LIFE_EN
  localparam logic [1:0] LivesStart = 2'(LIVES_INIT);
`else
  localparam logic [1:0] LivesStart = 2'd1;
`endif

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StHit  = 2'd2,
    StOver = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [13:0]       score_q, score_d;
  logic [13:0]       hi_q, hi_d;
  logic [1:0]        lives_q, lives_d;
  logic [DivW-1:0]   div_q, div_d;
  logic [InvW-1:0]   inv_q, inv_d;
  logic [FlashW-1:0] flash_cnt_q, flash_cnt_d;
  logic [FlashW-1:0] flash_cnt_inc;
  logic              blink_q, blink_d;
  logic              start_q;
  logic              start_arm_q, start_arm_d;
  logic              start_edge;
  logic              hit_ok;
  logic              go_over;
  logic              game_run_q, game_run_d;
  logic              hit_flash_q, hit_flash_d;
  logic              invuln_q, invuln_d;

  // A start level held through reset must not count as an edge: edges are only armed
  // after start_btn has been seen low at least once since reset.
  assign start_arm_d   = start_arm_q | ~gs.start_btn;
  assign start_edge    = gs.start_btn & ~start_q & start_arm_q;
  assign flash_cnt_inc = flash_cnt_q + FlashW'(1);
  assign hit_ok        = gs.frame_tick & gs.collision & (inv_q == '0);

  // State and datapath registers, all cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      score_q     <= '0;
      hi_q        <= '0;
      lives_q     <= '0;
      div_q       <= '0;
      inv_q       <= '0;
      flash_cnt_q <= '0;
      blink_q     <= 1'b0;
      start_q     <= 1'b0;
      start_arm_q <= 1'b0;
      game_run_q  <= 1'b0;
      hit_flash_q <= 1'b0;
      invuln_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      score_q     <= score_d;
      hi_q        <= hi_d;
      lives_q     <= lives_d;
      div_q       <= div_d;
      inv_q       <= inv_d;
      flash_cnt_q <= flash_cnt_d;
      blink_q     <= blink_d;
      start_q     <= gs.start_btn;
      start_arm_q <= start_arm_d;
      game_run_q  <= game_run_d;
      hit_flash_q <= hit_flash_d;
      invuln_q    <= invuln_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    score_d     = score_q;
    hi_d        = hi_q;
    lives_d     = lives_q;
    div_d       = div_q;
    inv_d       = inv_q;
    flash_cnt_d = flash_cnt_q;
    blink_d     = blink_q;
    go_over     = 1'b0;

    unique case (state_q)
      StIdle, StOver: begin
        if (start_edge) begin
          state_d = StRun;
          score_d = '0;
          div_d   = '0;
          inv_d   = '0;
          lives_d = LivesStart;
        end
      end

      StRun: begin
        if (gs.frame_tick) begin
          // Score advances even on the tick that loses a life
          if (div_q == DivW'(SCORE_DIV - 1)) begin
            div_d = '0;
            if (score_q != ScoreMax) score_d = score_q + 14'd1;
          end else begin
            div_d = div_q + DivW'(1);
          end
          if (inv_q != '0) inv_d = inv_q - InvW'(1);
          if (hit_ok) begin
`ifdef GAME_MULTI_LIFE_EN
            lives_d = lives_q - 2'd1;
            if (lives_q <= 2'd1) begin
              lives_d = 2'd0;
              go_over = 1'b1;
            end else begin
              state_d     = StHit;
              flash_cnt_d = '0;
              blink_d     = 1'b1;
            end
`else
            lives_d = 2'd0;
            go_over = 1'b1;
`endif
          end
          if (go_over) begin
            state_d = StOver;
            // Compare against the score including this tick's increment
            if (score_d > hi_q) hi_d = score_d;
          end
        end
      end

      StHit: begin
        if (gs.frame_tick) begin
          if (flash_cnt_inc == FlashW'(FLASH_FRAMES)) begin
            state_d     = StRun;
            flash_cnt_d = '0;
            inv_d       = InvW'(INVULN_FRAMES);
          end else begin
            flash_cnt_d = flash_cnt_inc;
            if (flash_cnt_inc[2:0] == 3'd0) blink_d = ~blink_q;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // Registered output values derived from the upcoming state.
  always_comb begin
    game_run_d  = (state_d == StRun);
    invuln_d    = (inv_d != '0);
    hit_flash_d = 1'b0;
    unique case (state_d)
      StRun:   hit_flash_d = (inv_d != '0) ? inv_d[3] : 1'b0;
      StHit:   hit_flash_d = blink_d;
      default: hit_flash_d = 1'b0;
    endcase
  end

  assign gs.state     = state_q;
  assign gs.game_run  = game_run_q;
  assign gs.hit_flash = hit_flash_q;
  assign gs.invuln    = invuln_q;
  assign gs.lives     = lives_q;
  assign gs.score     = score_q;
  assign gs.hi_score  = hi_q;

endmodule

// File: doc/game_state_ctrl.md
GAME_STATE_CTRL -- requirements
Module: game_state_ctrl

Interface
REQ-001 SHALL have parameter LIVES_INIT, default 3, lives loaded at game start (1..3).
REQ-002 SHALL have parameter FLASH_FRAMES, default 60, frames spent in HIT after a life is lost.
REQ-003 SHALL have parameter INVULN_FRAMES, default 90, invulnerability frames after HIT.
REQ-004 SHALL have parameter SCORE_DIV, default 6, frame ticks per score point.
REQ-005 SHALL have port clk  input  1  system clock; the single clock for all state.
REQ-006 SHALL have port rst_n  input  1  reset; asynchronous and active-low.
REQ-007 SHALL have port frame_tick  input  1  one-cycle pulse per video frame.
REQ-008 SHALL have port start_btn  input  1  start level, already synchronised to clk.
REQ-009 SHALL have port collision  input  1  combinational hit flag from collision_detector.
REQ-010 SHALL have port state  output  2  0=IDLE, 1=RUN, 2=HIT, 3=OVER.
REQ-011 SHALL have port game_run  output  1  high only in RUN; enables world/obstacle motion.
REQ-012 SHALL have port hit_flash  output  1  sprite blink enable.
REQ-013 SHALL have port invuln  output  1  high while the invulnerability counter is nonzero.
REQ-014 SHALL have port lives  output  2  remaining lives.
REQ-015 SHALL have port score  output  14  current score, binary.
REQ-016 SHALL have port hi_score  output  14  best score since reset.

Function
REQ-017 SHALL detect a start_btn rising edge from a registered copy; only edges act, never levels.
REQ-018 IDLE: a start edge SHALL go to RUN next cycle, clearing score, loading lives=LIVES_INIT, and clearing invuln.
REQ-019 RUN: a frame-tick divider SHALL increment score once per SCORE_DIV ticks; score saturates at 9999.
REQ-020 RUN: collision SHALL be sampled only in cycles where frame_tick=1; collision without frame_tick is ignored.
REQ-021 RUN: a sampled collision with invuln=1 SHALL be ignored.
REQ-022 RUN: a sampled collision with invuln=0 SHALL decrement lives. Next state is OVER if the result is 0, otherwise HIT.
REQ-023 If a score increment and an accepted collision fall on the same tick, the score increment SHALL still apply.
REQ-024 HIT: game_run=0, and score and divider SHALL freeze.
REQ-025 HIT: hit_flash SHALL toggle every 8 frame ticks, starting at 1 on entry.
REQ-026 HIT: after exactly FLASH_FRAMES ticks, SHALL return to RUN with the invuln counter set to INVULN_FRAMES.
REQ-027 invuln counter SHALL decrement once per frame_tick in RUN only. hit_flash SHALL follow bit 3 of that counter while it is nonzero in RUN, and is 0 otherwise.
REQ-028 On entry to OVER, hi_score SHALL load score if score > hi_score (same cycle as the transition). Equal scores leave hi_score unchanged.
REQ-029 OVER: a start edge SHALL behave exactly as in IDLE (REQ-018). Score remains visible until then.
REQ-030 A start edge in RUN or HIT SHALL be ignored.
REQ-031 All outputs SHALL be registered; state changes take effect 1 clk after the qualifying input cycle.

Reset
REQ-032 rst_n low SHALL asynchronously force: state=IDLE, score=0, hi_score=0, lives=0, invuln=0, hit_flash=0, game_run=0, all counters and edge register=0.
REQ-033 Reset asserted mid-game SHALL abandon the game. On release the block waits for a fresh start edge; a level held high through reset is not an edge.

Configuration
REQ-034 Macro GAME_MULTI_LIFE_EN defined: lives, HIT state and invulnerability behave per REQ-022..027.
REQ-035 Macro GAME_MULTI_LIFE_EN undefined: any sampled collision in RUN SHALL go directly to OVER. HIT is unreachable; lives is fixed at 1 during play; invuln and hit_flash stay 0.

Verification
REQ-036 Reset, then start edge, 60 ticks, no collision -> state=RUN, lives=3, score=10.
REQ-037 (MULTI_LIFE) collision on tick 30 -> lives=2, state=HIT. After 60 ticks state=RUN, invuln=1. Collision 10 ticks later is ignored.
REQ-038 (MULTI_LIFE) three separated collisions -> state=OVER after the third, lives=0, hi_score=final score. Restart, then fewer points before dying -> hi_score unchanged.
REQ-039 collision pulse in a cycle without frame_tick -> no state change. start_btn held high for 100 cycles in OVER -> exactly one restart.
REQ-040 Force score to 9998, 12 more ticks -> score=9999, then holds. Assert rst_n low in HIT -> all outputs 0 immediately, state=IDLE.
